// File: rtl/credit_sender.sv
// Credit-based link sender: forwards upstream data only while credits are available
// and tracks the receiver's reset state so credits restart cleanly from credit_initial.
module credit_sender #(
  parameter int WIDTH      = 8,
  parameter int MAX_CREDIT = 4,
  localparam int CW        = $clog2(MAX_CREDIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             push_ready,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_sender_in_reset,
  input  logic             pop_receiver_in_reset,
  input  logic             pop_credit,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic [CW-1:0]    credit_initial,
  input  logic [CW-1:0]    credit_withhold,
  output logic [CW-1:0]    credit_count,
  output logic [CW-1:0]    credit_available,
  output logic             err_overflow
);

  typedef enum logic [1:0] {INIT, ACTIVE, PEER_RESET} state_t;

  localparam logic [CW:0] MAX_EXT = (CW + 1)'(MAX_CREDIT);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count_next;
  logic [CW:0]   count_sum;
  logic          overflow_next;
  logic          accept;
  logic          forward;

  always_comb begin
    credit_available = '0;
    if (credit_count > credit_withhold) begin
      credit_available = credit_count - credit_withhold;
    end
    push_ready = (state == ACTIVE) && (credit_available != '0);
    accept     = push_valid && push_ready;
    // Data accepted as the receiver enters reset is discarded, never delivered.
    forward    = accept && !pop_receiver_in_reset;
    count_sum  = {1'b0, credit_count} + (CW + 1)'(pop_credit) - (CW + 1)'(accept);
  end

  always_comb begin
    state_next    = state;
    count_next    = credit_count;
    overflow_next = 1'b0;
    case (state)
      INIT: begin
        count_next = credit_initial;
        state_next = pop_receiver_in_reset ? PEER_RESET : ACTIVE;
      end
      ACTIVE: begin
        if (count_sum > MAX_EXT) begin
          count_next    = CW'(MAX_CREDIT);
          overflow_next = 1'b1;
        end else begin
          count_next = count_sum[CW-1:0];
        end
        if (pop_receiver_in_reset) begin
          state_next = PEER_RESET;
        end
      end
      PEER_RESET: begin
        count_next = credit_initial;
        if (!pop_receiver_in_reset) begin
          state_next = ACTIVE;
        end
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= INIT;
      credit_count        <= '0;
      err_overflow        <= 1'b0;
      pop_valid           <= 1'b0;
      pop_data            <= '0;
      pop_sender_in_reset <= 1'b1;
    end else begin
      state               <= state_next;
      credit_count        <= count_next;
      err_overflow        <= err_overflow | overflow_next;
      pop_valid           <= forward;
      pop_sender_in_reset <= 1'b0;
      if (forward) begin
        pop_data <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_credit_sender.sv
// Scenario bench for credit_sender: accepted pushes go into a queue and are
// popped and compared when the link side presents data.
module tb_credit_sender;
  localparam int WIDTH      = 8;
  localparam int MAX_CREDIT = 4;
  localparam int CW         = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_ready;
  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             pop_sender_in_reset;
  logic             pop_receiver_in_reset;
  logic             pop_credit;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic [CW-1:0]    credit_initial;
  logic [CW-1:0]    credit_withhold;
  logic [CW-1:0]    credit_count;
  logic [CW-1:0]    credit_available;
  logic             err_overflow;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_data;

  always #5 clk = ~clk;

  credit_sender #(.WIDTH(WIDTH), .MAX_CREDIT(MAX_CREDIT)) dut (
    .clk(clk), .rst(rst),
    .push_ready(push_ready), .push_valid(push_valid), .push_data(push_data),
    .pop_sender_in_reset(pop_sender_in_reset), .pop_receiver_in_reset(pop_receiver_in_reset),
    .pop_credit(pop_credit), .pop_valid(pop_valid), .pop_data(pop_data),
    .credit_initial(credit_initial), .credit_withhold(credit_withhold),
    .credit_count(credit_count), .credit_available(credit_available),
    .err_overflow(err_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (pop_sender_in_reset !== 1'b1 || credit_count !== 3'd0 || push_ready !== 1'b0 ||
        pop_valid !== 1'b0 || pop_data !== 8'h00 || err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold sir=%0b cnt=%0d rdy=%0b pv=%0b pd=%0h err=%0b exp 1/0/0/0/00/0",
               pop_sender_in_reset, credit_count, push_ready, pop_valid, pop_data, err_overflow);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pop_sender_in_reset !== 1'b0 || credit_count !== 3'd2 || push_ready !== 1'b1 || pop_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release sir=%0b cnt=%0d rdy=%0b pv=%0b exp 0/2/1/0",
               pop_sender_in_reset, credit_count, push_ready, pop_valid);
    end
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_stream();
    logic [CW-1:0] exp_cnt [3] = '{3'd1, 3'd0, 3'd0};
    logic [WIDTH-1:0] data [3] = '{8'hA1, 8'hA2, 8'hA3};
    push_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_data = data[i];
      #1;
      checks++;
      if (push_ready !== (i < 2)) begin
        failures++;
        $display("FAIL stream_ready beat=%0d got=%0b exp=%0b", i, push_ready, (i < 2));
      end
      if (i < 2) exp_q.push_back(data[i]);
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        if (pop_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_pop beat=%0d pop_valid=%0b exp 0", i, pop_valid);
        end
      end else begin
        exp_data = exp_q.pop_front();
        if (pop_valid !== 1'b1 || pop_data !== exp_data) begin
          failures++;
          $display("FAIL stream_pop beat=%0d pv=%0b pd=%0h exp 1/%0h", i, pop_valid, pop_data, exp_data);
        end
      end
      checks++;
      if (credit_count !== exp_cnt[i]) begin
        failures++;
        $display("FAIL stream_count beat=%0d got=%0d exp=%0d", i, credit_count, exp_cnt[i]);
      end
      $display("stream beat %0d data=%0h pv=%0b pd=%0h cnt=%0d", i, data[i], pop_valid, pop_data, credit_count);
    end
    push_valid = 1'b0;
  endtask

  task automatic test_credit_and_accept();
    pop_credit = 1'b1;
    tick();
    pop_credit = 1'b0;
    checks++;
    if (credit_count !== 3'd1) begin
      failures++;
      $display("FAIL credit_return got=%0d exp=1", credit_count);
    end
    push_valid = 1'b1;
    push_data  = 8'hB1;
    pop_credit = 1'b1;
    exp_q.push_back(8'hB1);
    tick();
    push_valid = 1'b0;
    pop_credit = 1'b0;
    exp_data = exp_q.pop_front();
    checks++;
    if (credit_count !== 3'd1 || pop_valid !== 1'b1 || pop_data !== exp_data) begin
      failures++;
      $display("FAIL credit_and_accept cnt=%0d pv=%0b pd=%0h exp 1/1/%0h", credit_count, pop_valid, pop_data, exp_data);
    end
    tick();
    checks++;
    if (pop_valid !== 1'b0 || pop_data !== 8'hB1 || credit_count !== 3'd1) begin
      failures++;
      $display("FAIL idle_hold pv=%0b pd=%0h cnt=%0d exp 0/b1/1", pop_valid, pop_data, credit_count);
    end
    $display("credit_and_accept cnt=%0d pd=%0h", credit_count, pop_data);
  endtask

  task automatic test_withhold();
    logic [CW-1:0] wh  [4] = '{3'd2, 3'd4, 3'd3, 3'd0};
    logic [CW-1:0] av  [4] = '{3'd1, 3'd0, 3'd0, 3'd3};
    logic          rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    pop_credit = 1'b1;
    repeat (2) tick();
    pop_credit = 1'b0;
    checks++;
    if (credit_count !== 3'd3) begin
      failures++;
      $display("FAIL withhold_setup got=%0d exp=3", credit_count);
    end
    for (int i = 0; i < 4; i++) begin
      credit_withhold = wh[i];
      #1;
      checks++;
      if (credit_available !== av[i] || push_ready !== rdy[i]) begin
        failures++;
        $display("FAIL withhold wh=%0d avail=%0d rdy=%0b exp %0d/%0b", wh[i], credit_available, push_ready, av[i], rdy[i]);
      end
      $display("withhold wh=%0d avail=%0d rdy=%0b", wh[i], credit_available, push_ready);
    end
    credit_withhold = '0;
  endtask

  task automatic test_overflow();
    pop_credit = 1'b1;
    tick();
    checks++;
    if (credit_count !== 3'd4 || err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_fill cnt=%0d err=%0b exp 4/0", credit_count, err_overflow);
    end
    tick();
    pop_credit = 1'b0;
    checks++;
    if (credit_count !== 3'd4 || err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set cnt=%0d err=%0b exp 4/1", credit_count, err_overflow);
    end
    repeat (3) tick();
    checks++;
    if (credit_count !== 3'd4 || err_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky cnt=%0d err=%0b exp 4/1", credit_count, err_overflow);
    end
    $display("overflow cnt=%0d err=%0b", credit_count, err_overflow);
  endtask

  task automatic test_peer_reset();
    push_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_data = 8'hC0 + 8'(k);
      exp_q.push_back(push_data);
      tick();
      exp_data = exp_q.pop_front();
      checks++;
      if (pop_valid !== 1'b1 || pop_data !== exp_data || credit_count !== 3'(3 - k)) begin
        failures++;
        $display("FAIL peer_traffic beat=%0d pv=%0b pd=%0h cnt=%0d exp 1/%0h/%0d",
                 k, pop_valid, pop_data, credit_count, exp_data, 3 - k);
      end
    end
    push_data = 8'hC4;
    pop_receiver_in_reset = 1'b1;
    pop_credit = 1'b1;
    tick();
    checks++;
    if (push_ready !== 1'b0 || pop_valid !== 1'b0 || pop_sender_in_reset !== 1'b0) begin
      failures++;
      $display("FAIL peer_enter rdy=%0b pv=%0b sir=%0b exp 0/0/0", push_ready, pop_valid, pop_sender_in_reset);
    end
    for (int k = 0; k < 3; k++) begin
      pop_credit = k[0];
      tick();
      checks++;
      if (credit_count !== 3'd2 || push_ready !== 1'b0 || pop_valid !== 1'b0) begin
        failures++;
        $display("FAIL peer_hold cyc=%0d cnt=%0d rdy=%0b pv=%0b exp 2/0/0", k, credit_count, push_ready, pop_valid);
      end
    end
    pop_receiver_in_reset = 1'b0;
    pop_credit = 1'b0;
    push_valid = 1'b0;
    tick();
    checks++;
    if (credit_count !== 3'd2 || push_ready !== 1'b1 || pop_valid !== 1'b0) begin
      failures++;
      $display("FAIL peer_exit cnt=%0d rdy=%0b pv=%0b exp 2/1/0", credit_count, push_ready, pop_valid);
    end
    $display("peer_reset exit cnt=%0d rdy=%0b", credit_count, push_ready);
  endtask

  task automatic test_async_reset();
    push_valid = 1'b1;
    push_data  = 8'hE1;
    exp_q.push_back(8'hE1);
    tick();
    push_valid = 1'b0;
    exp_data = exp_q.pop_front();
    checks++;
    if (pop_valid !== 1'b1 || pop_data !== exp_data || credit_count !== 3'd1) begin
      failures++;
      $display("FAIL async_pre pv=%0b pd=%0h cnt=%0d exp 1/%0h/1", pop_valid, pop_data, credit_count, exp_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pop_valid !== 1'b0 || pop_data !== 8'h00 || credit_count !== 3'd0 ||
        pop_sender_in_reset !== 1'b1 || err_overflow !== 1'b0 || push_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_clear pv=%0b pd=%0h cnt=%0d sir=%0b err=%0b rdy=%0b exp 0/00/0/1/0/0",
               pop_valid, pop_data, credit_count, pop_sender_in_reset, err_overflow, push_ready);
    end
    exp_q.delete();
    credit_initial = 3'd3;
    pop_receiver_in_reset = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (pop_sender_in_reset !== 1'b0 || credit_count !== 3'd3 || push_ready !== 1'b0 || err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL init_to_peer sir=%0b cnt=%0d rdy=%0b err=%0b exp 0/3/0/0",
               pop_sender_in_reset, credit_count, push_ready, err_overflow);
    end
    pop_receiver_in_reset = 1'b0;
    tick();
    checks++;
    if (credit_count !== 3'd3 || push_ready !== 1'b1 || pop_valid !== 1'b0) begin
      failures++;
      $display("FAIL peer_to_active cnt=%0d rdy=%0b pv=%0b exp 3/1/0", credit_count, push_ready, pop_valid);
    end
    $display("async_reset cnt=%0d rdy=%0b", credit_count, push_ready);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                   = 1'b1;
    push_valid            = 1'b0;
    push_data             = '0;
    pop_receiver_in_reset = 1'b0;
    pop_credit            = 1'b0;
    credit_initial        = 3'd2;
    credit_withhold       = '0;
    test_reset();
    test_stream();
    test_credit_and_accept();
    test_withhold();
    test_overflow();
    test_peer_reset();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/credit_sender.md
CREDIT_SENDER -- requirements
Module: credit_sender

Interface
REQ-001 Parameter WIDTH, default 8: pop_data/push_data width, >=1.
REQ-002 Parameter MAX_CREDIT, default 4: maximum credit count, >=1; CW = $clog2(MAX_CREDIT+1).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 push_ready  output  1  upstream may transfer this cycle.
REQ-006 push_valid  input  1  upstream data valid.
REQ-007 push_data  input  WIDTH  upstream data.
REQ-008 pop_sender_in_reset  output  1  tells receiver this sender is in reset.
REQ-009 pop_receiver_in_reset  input  1  receiver is in reset.
REQ-010 pop_credit  input  1  one credit returned by receiver per asserted cycle.
REQ-011 pop_valid  output  1  link data valid, no backpressure.
REQ-012 pop_data  output  WIDTH  link data.
REQ-013 credit_initial  input  CW  count loaded on init and on receiver-reset exit, <=MAX_CREDIT.
REQ-014 credit_withhold  input  CW  credits held back from use; may change any cycle.
REQ-015 credit_count  output  CW  current credit register.
REQ-016 credit_available  output  CW  usable credits.
REQ-017 err_overflow  output  1  sticky credit-overflow flag.

Function
REQ-018 FSM states: INIT, ACTIVE, PEER_RESET; rst forces INIT.
REQ-019 INIT: first clock after rst release loads credit_count=credit_initial; goes to PEER_RESET if pop_receiver_in_reset=1, else ACTIVE.
REQ-020 ACTIVE: pop_receiver_in_reset=1 goes to PEER_RESET next edge.
REQ-021 PEER_RESET: stays while pop_receiver_in_reset=1; pop_credit ignored; credit_count loads credit_initial every cycle; goes to ACTIVE on first cycle with pop_receiver_in_reset=0.
REQ-022 credit_available = credit_count - credit_withhold if credit_count > credit_withhold, else 0 (combinational, no underflow).
REQ-023 push_ready = (state==ACTIVE) && (credit_available != 0); no same-cycle bypass of pop_credit.
REQ-024 Accept = push_valid && push_ready.
REQ-025 In ACTIVE: credit_count_next = credit_count + pop_credit - accept; simultaneous credit and accept leave count unchanged.
REQ-026 Increment that would exceed MAX_CREDIT: count holds at MAX_CREDIT, err_overflow set, stays 1 until rst.
REQ-027 pop_valid, pop_data registered: accept in cycle N gives pop_valid=1, pop_data=push_data in N+1; 1-cycle latency.
REQ-028 pop_data holds last value when no accept; pop_valid=0 in any cycle following a non-accept.
REQ-029 pop_valid never asserts while state is INIT or PEER_RESET, or in the cycle after leaving them without an accept.
REQ-030 Entering PEER_RESET drops pop_valid next edge; no in-flight data is retained.
REQ-031 Counter arithmetic in CW+1 bits internally; no wrap.

Reset
REQ-032 During rst: pop_sender_in_reset=1, state=INIT, credit_count=0, pop_valid=0, pop_data=0, err_overflow=0, push_ready=0.
REQ-033 pop_sender_in_reset deasserts on first rising edge after rst low; registered, glitch-free.
REQ-034 rst asserted mid-transfer clears all state immediately and asynchronously; pending pop_valid dropped.

Verification (MAX_CREDIT=4, WIDTH=8, credit_initial=2, credit_withhold=0 unless stated)
REQ-035 rst=1 then released -> during rst pop_sender_in_reset=1, credit_count=0, push_ready=0; one edge after release pop_sender_in_reset=0, credit_count=2, push_ready=1.
REQ-036 push_valid=1 continuously, data 0xA1,0xA2,0xA3 -> pop shows 0xA1 then 0xA2 one cycle after each accept; push_ready=0 after second accept; credit_count=0; 0xA3 not sent.
REQ-037 credit_count=1, accept and pop_credit same cycle -> credit_count stays 1, pop_valid=1 next cycle.
REQ-038 credit_count=3, credit_withhold=2 -> credit_available=1; credit_withhold=4 -> credit_available=0, push_ready=0, no underflow.
REQ-039 credit_count=4, pop_credit=1, no accept -> credit_count=4, err_overflow=1, stays 1 until rst.
REQ-040 pop_receiver_in_reset=1 during traffic with credit_count=1, pop_credit pulses -> push_ready=0, pop_valid=0 next cycle, credits ignored; on deassert credit_count=2, push_ready=1.
